exc_entry_seq: RTL and testbench

//  Exception-entry sequencer; the writer side of GeneralReg's banked write port.
//  - Arbitrates pending exception requests and selects the target mode.
//  - Writes SPSR, the target-mode banked LR (R14) and PC (R15), then updates CPSR.
//  - Sits between the core's exception sources and the register file; the core stalls while busy=1.

---
 rtl/arm_mode_pkg.sv | 47 ++++
 rtl/exc_prio_arb.sv | 24 ++
 rtl/exc_entry_seq.sv | 128 ++++++++++++
 tb/tb_exc_entry_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mode_pkg.sv
// arm_mode_pkg: mode codes, exception indices, vector offsets and sequencer states
package arm_mode_pkg;

   localparam logic [4:0] MODE_USR = 5'h10;
   localparam logic [4:0] MODE_FIQ = 5'h11;
   localparam logic [4:0] MODE_IRQ = 5'h12;
   localparam logic [4:0] MODE_ABT = 5'h13;
   localparam logic [4:0] MODE_SVC = 5'h16;
   localparam logic [4:0] MODE_UND = 5'h17;

   localparam int EXC_DABT = 0;
   localparam int EXC_FIQ  = 1;
   localparam int EXC_IRQ  = 2;
   localparam int EXC_PABT = 3;
   localparam int EXC_SVC  = 4;
   localparam int EXC_UND  = 5;

   localparam logic [7:0] VEC_DABT = 8'h10;
   localparam logic [7:0] VEC_FIQ  = 8'h1C;
   localparam logic [7:0] VEC_IRQ  = 8'h18;
   localparam logic [7:0] VEC_PABT = 8'h0C;
   localparam logic [7:0] VEC_SVC  = 8'h08;
   localparam logic [7:0] VEC_UND  = 8'h04;

   typedef enum logic [1:0] {ST_IDLE, ST_SPSR, ST_LR, ST_PC} state_t;

   // Target mode of a one-hot winner
   function automatic logic [4:0] exc_mode(input logic [5:0] oh);
      return oh[EXC_DABT] ? MODE_ABT :
             oh[EXC_FIQ]  ? MODE_FIQ :
             oh[EXC_IRQ]  ? MODE_IRQ :
             oh[EXC_PABT] ? MODE_ABT :
             oh[EXC_SVC]  ? MODE_SVC :
             oh[EXC_UND]  ? MODE_UND : MODE_USR;
   endfunction

   // Vector offset of a one-hot winner
   function automatic logic [7:0] exc_vec(input logic [5:0] oh);
      return oh[EXC_DABT] ? VEC_DABT :
             oh[EXC_FIQ]  ? VEC_FIQ  :
             oh[EXC_IRQ]  ? VEC_IRQ  :
             oh[EXC_PABT] ? VEC_PABT :
             oh[EXC_SVC]  ? VEC_SVC  :
             oh[EXC_UND]  ? VEC_UND  : 8'h00;
   endfunction

endpackage

// File: rtl/exc_prio_arb.sv
// exc_prio_arb: masks FIQ/IRQ and picks the lowest-index pending request
module exc_prio_arb
   import arm_mode_pkg::*;
(
   input  logic [5:0] i_req,
   input  logic       i_irq_mask,
   input  logic       i_fiq_mask,
   output logic [5:0] o_win,
   output logic       o_valid
);

   logic [5:0] w_req;

   // Drop the maskable requests whose CPSR disable bit is set
   always_comb begin
      w_req = i_req;
      w_req[EXC_FIQ] = i_req[EXC_FIQ] & ~i_fiq_mask;
      w_req[EXC_IRQ] = i_req[EXC_IRQ] & ~i_irq_mask;
   end

   assign o_win   = w_req & (~w_req + 6'd1);
   assign o_valid = |w_req;

endmodule

// File: rtl/exc_entry_seq.sv
// exc_entry_seq: exception-entry sequencer writing SPSR, banked LR/PC and CPSR
module exc_entry_seq
   import arm_mode_pkg::*;
#(
   parameter logic [31:0] LR_OFS_DEF  = 32'd4,
   parameter logic [31:0] LR_OFS_DABT = 32'd8,
   parameter bit          FIQ_SETS_F  = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  i_exc_req,
   input  logic [31:0] i_cur_cpsr,
   input  logic [31:0] i_cur_pc,
   input  logic [31:0] i_vec_base,
   output logic        o_busy,
   output logic        o_write_reg,
   output logic [3:0]  o_w_addr,
   output logic [31:0] o_w_data,
   output logic [4:0]  o_mod,
   output logic        o_spsr_we,
   output logic [31:0] o_spsr_data,
   output logic        o_cpsr_we,
   output logic [31:0] o_cpsr_data,
   output logic [5:0]  o_exc_ack
);

   state_t      r_state, w_next;
   logic [5:0]  r_win, w_win;
   logic        w_valid;
   logic [31:0] r_cpsr, r_pc, w_vec;
   logic        w_we, w_spsr_we, w_cpsr_we;
   logic [3:0]  w_addr;
   logic [31:0] w_data, w_spsr_data, w_cpsr_data;
   logic [5:0]  w_ack;
   logic        w_f;

   exc_prio_arb u_arb (
      .i_req      (i_exc_req),
      .i_irq_mask (i_cur_cpsr[7]),
      .i_fiq_mask (i_cur_cpsr[6]),
      .o_win      (w_win),
      .o_valid    (w_valid)
   );

   assign w_vec  = i_vec_base & ~32'h1F;
   assign w_f    = (r_win[EXC_FIQ] && FIQ_SETS_F) ? 1'b1 : r_cpsr[6];
   assign o_busy = (r_state != ST_IDLE);
   assign o_mod  = (r_state == ST_IDLE) ? i_cur_cpsr[4:0] : exc_mode(r_win);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next state and the strobes to be presented in that state
   always_comb begin
      w_next      = r_state;
      w_we        = 1'b0;
      w_addr      = 4'h0;
      w_data      = '0;
      w_spsr_we   = 1'b0;
      w_spsr_data = '0;
      w_cpsr_we   = 1'b0;
      w_cpsr_data = '0;
      w_ack       = '0;
      case (r_state)
         ST_IDLE: if (w_valid) begin
            w_next      = ST_SPSR;
            w_spsr_we   = 1'b1;
            w_spsr_data = i_cur_cpsr;
         end
         ST_SPSR: begin
            w_next = ST_LR;
            w_we   = 1'b1;
            w_addr = 4'hE;
            w_data = r_pc + (r_win[EXC_DABT] ? LR_OFS_DABT : LR_OFS_DEF);
         end
         ST_LR: begin
            w_next      = ST_PC;
            w_we        = 1'b1;
            w_addr      = 4'hF;
            w_data      = w_vec + {24'b0, exc_vec(r_win)};
            w_cpsr_we   = 1'b1;
            w_cpsr_data = {r_cpsr[31:8], 1'b1, w_f, 1'b0, exc_mode(r_win)};
            w_ack       = r_win;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Capture winner and context at entry so the sequence ignores later input changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win  <= '0;
         r_cpsr <= '0;
         r_pc   <= '0;
      end else if (r_state == ST_IDLE && w_valid) begin
         r_win  <= w_win;
         r_cpsr <= i_cur_cpsr;
         r_pc   <= i_cur_pc;
      end
   end

   // Registered strobes and data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_write_reg <= 1'b0;
         o_w_addr    <= 4'h0;
         o_w_data    <= '0;
         o_spsr_we   <= 1'b0;
         o_spsr_data <= '0;
         o_cpsr_we   <= 1'b0;
         o_cpsr_data <= '0;
         o_exc_ack   <= '0;
      end else begin
         o_write_reg <= w_we;
         o_w_addr    <= w_addr;
         o_w_data    <= w_data;
         o_spsr_we   <= w_spsr_we;
         o_spsr_data <= w_spsr_data;
         o_cpsr_we   <= w_cpsr_we;
         o_cpsr_data <= w_cpsr_data;
         o_exc_ack   <= w_ack;
      end
   end

endmodule

// File: tb/tb_exc_entry_seq.sv
// tb_exc_entry_seq: directed and random checks of exc_entry_seq against a cycle-queue model
module tb_exc_entry_seq;

   logic        clk, rst_n;
   logic [5:0]  i_exc_req;
   logic [31:0] i_cur_cpsr, i_cur_pc, i_vec_base;
   logic        o_busy, o_write_reg, o_spsr_we, o_cpsr_we;
   logic [3:0]  o_w_addr;
   logic [31:0] o_w_data, o_spsr_data, o_cpsr_data;
   logic [4:0]  o_mod;
   logic [5:0]  o_exc_ack;

   exc_entry_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_exc_req   (i_exc_req),
      .i_cur_cpsr  (i_cur_cpsr),
      .i_cur_pc    (i_cur_pc),
      .i_vec_base  (i_vec_base),
      .o_busy      (o_busy),
      .o_write_reg (o_write_reg),
      .o_w_addr    (o_w_addr),
      .o_w_data    (o_w_data),
      .o_mod       (o_mod),
      .o_spsr_we   (o_spsr_we),
      .o_spsr_data (o_spsr_data),
      .o_cpsr_we   (o_cpsr_we),
      .o_cpsr_data (o_cpsr_data),
      .o_exc_ack   (o_exc_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  mod;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] data;
      logic        spsr_we;
      logic [31:0] spsr_data;
      logic        cpsr_we;
      logic [31:0] cpsr_data;
      logic [5:0]  ack;
   } rec_t;

   // Expected output of each upcoming busy cycle; empty means idle
   rec_t q[$];

   logic [4:0]  mode_tab [6] = '{5'h13, 5'h11, 5'h12, 5'h13, 5'h16, 5'h17};
   logic [31:0] vec_tab  [6] = '{32'h10, 32'h1C, 32'h18, 32'h0C, 32'h08, 32'h04};

   int n_chk = 0, n_err = 0, n_ack = 0;
   logic [31:0] cap_spsr, cap_lr, cap_pc, cap_cpsr;
   logic [4:0]  cap_lr_mod;
   logic [5:0]  cap_ack;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: an idle cycle with an unmasked request queues three write cycles
   always @(posedge clk) begin
      int w;
      rec_t r;
      if (!rst_n) q.delete();
      else if (q.size() != 0) void'(q.pop_front());
      else begin
         w = -1;
         for (int i = 0; i < 6; i++)
            if (w < 0 && i_exc_req[i] && !(i == 1 && i_cur_cpsr[6]) && !(i == 2 && i_cur_cpsr[7]))
               w = i;
         if (w >= 0) begin
            r = '{mode_tab[w], 1'b0, 4'h0, 32'h0, 1'b1, i_cur_cpsr, 1'b0, 32'h0, 6'h0};
            q.push_back(r);
            r = '{mode_tab[w], 1'b1, 4'hE, i_cur_pc + ((w == 0) ? 32'd8 : 32'd4),
                  1'b0, 32'h0, 1'b0, 32'h0, 6'h0};
            q.push_back(r);
            r = '{mode_tab[w], 1'b1, 4'hF, (i_vec_base & 32'hFFFF_FFE0) + vec_tab[w],
                  1'b0, 32'h0, 1'b1,
                  {i_cur_cpsr[31:8], 1'b1, (w == 1) ? 1'b1 : i_cur_cpsr[6], 1'b0, mode_tab[w]},
                  6'(1 << w)};
            q.push_back(r);
         end
      end
   end

   // Compare every cycle's outputs with the model, and record the last writes seen
   always @(negedge clk) begin
      rec_t e;
      e = '{i_cur_cpsr[4:0], 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0};
      if (q.size() != 0) e = q[0];
      chk("busy", 32'(o_busy), 32'(q.size() != 0));
      chk("mod", 32'(o_mod), 32'(e.mod));
      chk("write_reg", 32'(o_write_reg), 32'(e.we));
      if (e.we) begin
         chk("w_addr", 32'(o_w_addr), 32'(e.addr));
         chk("w_data", o_w_data, e.data);
      end
      chk("spsr_we", 32'(o_spsr_we), 32'(e.spsr_we));
      if (e.spsr_we) chk("spsr_data", o_spsr_data, e.spsr_data);
      chk("cpsr_we", 32'(o_cpsr_we), 32'(e.cpsr_we));
      if (e.cpsr_we) chk("cpsr_data", o_cpsr_data, e.cpsr_data);
      chk("exc_ack", 32'(o_exc_ack), 32'(e.ack));
      if (o_spsr_we) cap_spsr = o_spsr_data;
      if (o_write_reg && o_w_addr == 4'hE) begin
         cap_lr = o_w_data;
         cap_lr_mod = o_mod;
      end
      if (o_write_reg && o_w_addr == 4'hF) cap_pc = o_w_data;
      if (o_cpsr_we) cap_cpsr = o_cpsr_data;
      if (o_exc_ack != 6'h0) begin
         cap_ack = o_exc_ack;
         n_ack++;
      end
   end

   initial begin
      int acks;
      rst_n = 1'b0;
      i_exc_req = '0;
      i_cur_cpsr = 32'h10;
      i_cur_pc = '0;
      i_vec_base = '0;
      step(2);
      chk("rst busy", 32'(o_busy), 32'h0);
      chk("rst write_reg", 32'(o_write_reg), 32'h0);
      chk("rst w_addr", 32'(o_w_addr), 32'h0);
      chk("rst w_data", o_w_data, 32'h0);
      chk("rst spsr", {31'b0, o_spsr_we} | o_spsr_data, 32'h0);
      chk("rst cpsr", {31'b0, o_cpsr_we} | o_cpsr_data, 32'h0);
      chk("rst ack", 32'(o_exc_ack), 32'h0);
      chk("rst mod", 32'(o_mod), 32'h10);
      rst_n = 1'b1;
      step(1);

      // IRQ only
      i_cur_pc = 32'h100;
      i_exc_req = 6'b000100;
      step(1);
      i_exc_req = '0;
      step(4);
      chk("t1 spsr", cap_spsr, 32'h10);
      chk("t1 lr", cap_lr, 32'h104);
      chk("t1 lr mod", 32'(cap_lr_mod), 32'h12);
      chk("t1 pc", cap_pc, 32'h18);
      chk("t1 cpsr", cap_cpsr, 32'h92);
      chk("t1 ack", 32'(cap_ack), 32'h4);

      // FIQ+IRQ+DABT together: DABT first, then FIQ
      i_cur_pc = 32'h200;
      i_exc_req = 6'b000111;
      step(4);
      chk("t2 dabt lr", cap_lr, 32'h208);
      chk("t2 dabt mod", 32'(cap_lr_mod), 32'h13);
      chk("t2 dabt pc", cap_pc, 32'h10);
      chk("t2 dabt ack", 32'(cap_ack), 32'h1);
      i_exc_req = 6'b000110;
      step(1);
      i_exc_req = '0;
      step(4);
      chk("t2 fiq lr", cap_lr, 32'h204);
      chk("t2 fiq pc", cap_pc, 32'h1C);
      chk("t2 fiq cpsr", cap_cpsr, 32'hD1);
      chk("t2 fiq ack", 32'(cap_ack), 32'h2);

      // Masked FIQ is ignored, then UND
      acks = n_ack;
      i_cur_cpsr = 32'h50;
      i_vec_base = 32'h1000;
      i_exc_req = 6'b000010;
      step(4);
      chk("t3 no ack", 32'(n_ack), 32'(acks));
      i_exc_req = 6'b100010;
      step(1);
      i_exc_req = '0;
      step(4);
      chk("t3 und pc", cap_pc, 32'h1004);
      chk("t3 und mod", 32'(cap_lr_mod), 32'h17);
      chk("t3 und cpsr", cap_cpsr, 32'hD7);
      chk("t3 und ack", 32'(cap_ack), 32'h20);

      // Vector base low bits ignored, LR wraps
      i_cur_cpsr = 32'h10;
      i_vec_base = 32'hFFFF_001F;
      i_cur_pc = 32'hFFFF_FFFC;
      i_exc_req = 6'b010000;
      step(1);
      i_exc_req = '0;
      step(4);
      chk("t4 pc", cap_pc, 32'hFFFF_0008);
      chk("t4 lr wrap", cap_lr, 32'h0);
      chk("t4 mod", 32'(cap_lr_mod), 32'h16);

      // Reset while in LR state
      acks = n_ack;
      i_cur_pc = 32'h300;
      i_exc_req = 6'b010000;
      step(1);
      i_exc_req = '0;
      step(1);
      chk("t5 in lr", 32'(o_write_reg), 32'h1);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("t5 rst write_reg", 32'(o_write_reg), 32'h0);
      chk("t5 rst busy", 32'(o_busy), 32'h0);
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("t5 no ack", 32'(n_ack), 32'(acks));
      chk("t5 no pc write", cap_pc, 32'hFFFF_0008);

      // Inputs toggled during the sequence do not matter
      i_cur_pc = 32'h400;
      i_exc_req = 6'b001000;
      step(1);
      i_exc_req = '0;
      repeat (3) begin
         i_cur_pc = $urandom;
         i_cur_cpsr = $urandom;
         step(1);
      end
      i_cur_cpsr = 32'h10;
      step(2);
      chk("t6 spsr", cap_spsr, 32'h10);
      chk("t6 lr", cap_lr, 32'h404);
      chk("t6 pc", cap_pc, 32'hFFFF_000C);
      chk("t6 cpsr", cap_cpsr, 32'h93);
      chk("t6 ack", 32'(cap_ack), 32'h8);

      // Random traffic; vector base only changes while idle
      repeat (600) begin
         i_exc_req = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
         i_cur_cpsr = $urandom;
         i_cur_pc = $urandom;
         if (q.size() == 0 && $urandom_range(0, 7) == 0) i_vec_base = $urandom;
         step(1);
      end
      i_exc_req = '0;
      step(5);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
